// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with valid/ready byte input, optional parity and one or two stop bits
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int UART_BPS  = 115_200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       uart_tx_busy,
  output logic       uart_tx_done
);
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CW = $clog2(BAUD_CNT_MAX + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_d;
  logic [CW-1:0] baud_cnt, baud_d;
  logic [2:0] bit_cnt, bit_d;
  logic [7:0] shift, shift_d;
  logic txd_d, wrap;
  assign wrap = state != IDLE && baud_cnt == CW'(BAUD_CNT_MAX - 1);
  assign tx_ready = state == IDLE;
  assign uart_tx_busy = state != IDLE;
  assign uart_tx_done = state == STOP && wrap && bit_cnt == 3'(STOP_BITS - 1);
  always_comb begin
    state_d = state;
    baud_d = wrap ? '0 : (state == IDLE ? '0 : baud_cnt + 1'b1);
    bit_d = bit_cnt;
    shift_d = shift;
    txd_d = uart_txd;
    case (state)
      IDLE: begin
        state_d = tx_valid ? START : IDLE;
        shift_d = tx_valid ? tx_data : shift;
        txd_d = !tx_valid;
      end
      START: begin
        state_d = wrap ? DATA : START;
        bit_d = wrap ? 3'd0 : bit_cnt;
        txd_d = wrap ? shift[0] : uart_txd;
      end
      DATA: begin
        if (wrap && bit_cnt == 3'd7) begin
          state_d = PARITY != 0 ? PAR : STOP;
          bit_d = 3'd0;
          txd_d = PARITY != 0 ? (^shift ^ (PARITY == 1)) : 1'b1;
        end else if (wrap) begin
          bit_d = bit_cnt + 3'd1;
          txd_d = shift[bit_cnt + 3'd1];
        end
      end
      PAR: begin
        state_d = wrap ? STOP : PAR;
        txd_d = wrap ? 1'b1 : uart_txd;
      end
      STOP: begin
        state_d = uart_tx_done ? IDLE : STOP;
        bit_d = uart_tx_done ? 3'd0 : (wrap ? bit_cnt + 3'd1 : bit_cnt);
        txd_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      state <= state_d;
      baud_cnt <= baud_d;
      bit_cnt <= bit_d;
      shift <= shift_d;
      uart_txd <= txd_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench comparing four uart_tx configurations against a frame model
module tb_uart_tx;
  localparam int BAUD = 10;
  localparam int PAR_OF [4] = '{0, 2, 1, 0};
  localparam int STP_OF [4] = '{1, 1, 1, 2};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] valid = 4'b0;
  logic [3:0] ready, txd, busy, done;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .rst(rst),
    .tx_valid(valid[0]), .tx_data(tx_data), .tx_ready(ready[0]), .uart_txd(txd[0]), .uart_tx_busy(busy[0]), .uart_tx_done(done[0]));
  uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(2), .STOP_BITS(1)) u1 (.clk(clk), .rst(rst),
    .tx_valid(valid[1]), .tx_data(tx_data), .tx_ready(ready[1]), .uart_txd(txd[1]), .uart_tx_busy(busy[1]), .uart_tx_done(done[1]));
  uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(1), .STOP_BITS(1)) u2 (.clk(clk), .rst(rst),
    .tx_valid(valid[2]), .tx_data(tx_data), .tx_ready(ready[2]), .uart_txd(txd[2]), .uart_tx_busy(busy[2]), .uart_tx_done(done[2]));
  uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY(0), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst),
    .tx_valid(valid[3]), .tx_data(tx_data), .tx_ready(ready[3]), .uart_txd(txd[3]), .uart_tx_busy(busy[3]), .uart_tx_done(done[3]));
  function automatic int frame_len(input int par, input int stops);
    return (1 + 8 + (par != 0 ? 1 : 0) + stops) * BAUD;
  endfunction
  function automatic logic [0:299] wave(input logic [7:0] b, input int par, input int stops, input int off);
    logic [0:299] w;
    logic bits[$];
    w = '1;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par == 2) bits.push_back(($countones(b) % 2) == 1);
    if (par == 1) bits.push_back(($countones(b) % 2) == 0);
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    for (int i = 0; i < bits.size() * BAUD; i++)
      if (off + i < 300) w[off + i] = bits[i / BAUD];
    return w;
  endfunction
  function automatic logic [0:299] busy_wave(input int len);
    logic [0:299] w;
    w = '0;
    for (int i = 0; i < len; i++) w[i] = 1'b1;
    return w;
  endfunction
  task automatic send(input int k, input logic [7:0] b, input int n, output logic [0:299] w,
                      output logic [0:299] wb, output int done_at, output int n_done, output int ready_at);
    w = '1;
    wb = '0;
    done_at = 0;
    n_done = 0;
    ready_at = 0;
    @(negedge clk);
    tx_data = b;
    valid[k] = 1'b1;
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
    tx_data = 8'($urandom);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      w[c-1] = txd[k];
      wb[c-1] = busy[k];
      if (done[k]) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
      if (ready[k] && ready_at == 0) ready_at = c;
    end
  endtask
  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({txd[k], ready[k], busy[k], done[k]} !== 4'b1100) begin
        n_bad++;
        $display("FAIL reset_state inst%0d: got txd/ready/busy/done=%b want 1100", k, {txd[k], ready[k], busy[k], done[k]});
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_8n1;
    logic [0:299] w, wb;
    int d, nd, r;
    logic [7:0] b;
    send(0, 8'h55, 130, w, wb, d, nd, r);
    n_cmp++;
    if (w !== wave(8'h55, 0, 1, 0)) begin
      n_bad++;
      $display("FAIL 8n1_wave_55: got %h want %h", w, wave(8'h55, 0, 1, 0));
    end
    n_cmp++;
    if (d !== 100 || nd !== 1) begin
      n_bad++;
      $display("FAIL 8n1_done: got clk %0d count %0d want clk 100 count 1", d, nd);
    end
    n_cmp++;
    if (r !== 101) begin
      n_bad++;
      $display("FAIL 8n1_ready: got clk %0d want 101", r);
    end
    n_cmp++;
    if (wb !== busy_wave(100)) begin
      n_bad++;
      $display("FAIL 8n1_busy: got %h want %h", wb, busy_wave(100));
    end
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send(0, b, 130, w, wb, d, nd, r);
      n_cmp++;
      if (w !== wave(b, 0, 1, 0) || d !== 100) begin
        n_bad++;
        $display("FAIL 8n1_rand_%h: got wave %h done %0d want %h done 100", b, w, d, wave(b, 0, 1, 0));
      end
    end
  endtask
  task automatic test_parity;
    logic [0:299] w, wb;
    int d, nd, r;
    for (int k = 1; k <= 2; k++) begin
      send(k, 8'h07, 130, w, wb, d, nd, r);
      n_cmp++;
      if (w[95] !== (k == 1)) begin
        n_bad++;
        $display("FAIL parity_bit_07 inst%0d: got %b want %b", k, w[95], k == 1);
      end
      n_cmp++;
      if (w !== wave(8'h07, PAR_OF[k], 1, 0) || d !== 110 || r !== 111) begin
        n_bad++;
        $display("FAIL parity_frame_07 inst%0d: got %h done %0d ready %0d want %h done 110 ready 111",
                 k, w, d, r, wave(8'h07, PAR_OF[k], 1, 0));
      end
    end
  endtask
  task automatic test_stop2;
    logic [0:299] w, wb;
    int d, nd, r;
    send(3, 8'hFF, 130, w, wb, d, nd, r);
    n_cmp++;
    if (w !== wave(8'hFF, 0, 2, 0)) begin
      n_bad++;
      $display("FAIL stop2_wave_ff: got %h want %h", w, wave(8'hFF, 0, 2, 0));
    end
    n_cmp++;
    if (d !== 110 || nd !== 1 || wb !== busy_wave(110)) begin
      n_bad++;
      $display("FAIL stop2_done: got clk %0d count %0d busy %h want clk 110 count 1", d, nd, wb);
    end
  endtask
  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
    logic [0:299] w, e;
    int s2;
    w = '1;
    s2 = -1;
    @(negedge clk);
    tx_data = a;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_data = b;
    for (int c = 1; c <= 250; c++) begin
      @(negedge clk);
      w[c-1] = txd[0];
      if (c > 100 && !txd[0] && s2 < 0) s2 = c - 1;
      if (ready[0] && valid[0]) begin
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
      end
    end
    valid[0] = 1'b0;
    e = wave(a, 0, 1, 0) & wave(b, 0, 1, 101);
    n_cmp++;
    if (w !== e) begin
      n_bad++;
      $display("FAIL b2b_wave_%h_%h: got %h want %h", a, b, w, e);
    end
    n_cmp++;
    if (s2 !== 101) begin
      n_bad++;
      $display("FAIL b2b_start_gap: got %0d want 101", s2);
    end
  endtask
  task automatic test_reset_midframe;
    logic [0:299] w, wb;
    int d, nd, r, nd_abort, hi;
    nd_abort = 0;
    hi = 0;
    @(negedge clk);
    tx_data = 8'h00;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      nd_abort += int'(done[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({txd[0], ready[0], busy[0], done[0]} !== 4'b1100) begin
      n_bad++;
      $display("FAIL midframe_reset: got txd/ready/busy/done=%b want 1100", {txd[0], ready[0], busy[0], done[0]});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nd_abort += int'(done[0]);
      hi += int'(txd[0]);
    end
    n_cmp++;
    if (nd_abort !== 0 || hi !== 20) begin
      n_bad++;
      $display("FAIL abort_no_done: got done count %0d idle-high cycles %0d want 0 and 20", nd_abort, hi);
    end
    send(0, 8'h81, 130, w, wb, d, nd, r);
    n_cmp++;
    if (w !== wave(8'h81, 0, 1, 0) || d !== 100) begin
      n_bad++;
      $display("FAIL after_reset_81: got %h done %0d want %h done 100", w, d, wave(8'h81, 0, 1, 0));
    end
  endtask
  task automatic test_random;
    logic [0:299] w, wb;
    int d, nd, r, k, len;
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 3);
      b = 8'($urandom);
      len = frame_len(PAR_OF[k], STP_OF[k]);
      send(k, b, 130, w, wb, d, nd, r);
      n_cmp++;
      if (w !== wave(b, PAR_OF[k], STP_OF[k], 0) || wb !== busy_wave(len)) begin
        n_bad++;
        $display("FAIL rand_wave inst%0d byte %h: got %h busy %h want %h", k, b, w, wb, wave(b, PAR_OF[k], STP_OF[k], 0));
      end
      n_cmp++;
      if (d !== len || nd !== 1 || r !== len + 1) begin
        n_bad++;
        $display("FAIL rand_timing inst%0d: got done %0d x%0d ready %0d want done %0d x1 ready %0d", k, d, nd, r, len, len + 1);
      end
    end
  endtask
  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_stop2;
    test_back_to_back(8'hA5, 8'h3C);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_reset_midframe;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
